// File: rtl/tone_arbiter_pkg.sv
// Shared definitions for the tone arbiter: bus widths, FSM state type and
// the index-width helper used by the arbiter, its interface and tick_gen.
package tone_pkg;

  localparam int TONE_W = 24;
  localparam int DUR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Width needed to hold an index 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tone_arbiter_if.sv
// Request bus between the note sources and the tone arbiter. Each requester
// owns one valid/ready pair plus a tone slice and a duration slice.
interface tone_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import tone_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [TONE_W*NUM_REQ-1:0] req_tone;
  logic [DUR_W*NUM_REQ-1:0]  req_duration;

  modport master (
    output req_valid,
    output req_tone,
    output req_duration,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_tone,
    input  req_duration,
    output req_ready
  );

endinterface

// File: rtl/tone_arbiter_tick_gen.sv
// Free-running duration tick generator. The counter wraps at TICK_CYCLES-1
// and the tick is high in the wrap cycle; restart zeroes it synchronously so
// a note or gap always starts on a fresh tick boundary.
module tick_gen
  import tone_pkg::*;
#(
  parameter int TICK_CYCLES = 33000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int                 CNT_W = idx_w(TICK_CYCLES);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap on tick, zero on restart.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_arbiter.sv
// Tone arbiter: grants one note source at a time to the shared piezo
// tone_generator, plays the note for its duration in ticks, then holds a
// silent articulation gap before the next grant.
// Build option: define TONE_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with the lowest index winning.
module tone_arbiter
  import tone_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_CYCLES = 33000,
  parameter int GAP_TICKS   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  tone_arbiter_if.slave               req,
  input  logic                        abort,
  output logic [TONE_W-1:0]           tone_switch_period,
  output logic                        output_enable,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        note_done
);

  localparam int IDX_W     = idx_w(NUM_REQ);
  localparam int GAP_CNT_W = idx_w(GAP_TICKS + 1);

  state_t               state_q, state_d;
  logic [TONE_W-1:0]    tone_q, tone_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic [IDX_W-1:0]     gid_q, gid_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [TONE_W-1:0]  win_tone;
  logic [DUR_W-1:0]   win_dur;
  logic               accept;
  logic               restart;
  logic               tick;
  logic               last_cycle;

`ifdef TONE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  // Duration countdown that holds at zero instead of wrapping.
  function automatic logic [DUR_W-1:0] dur_dec(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Winner search; round-robin starts just after the last grant.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    win_tone  = '0;
    win_dur   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef TONE_ARB_ROUND_ROBIN_EN
      j = (int'(ptr_q) + 1 + k) % NUM_REQ;
`else
      j = k;
`endif
      if (!win_found && req.req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
        win_tone  = req.req_tone[j*TONE_W +: TONE_W];
        win_dur   = req.req_duration[j*DUR_W +: DUR_W];
      end
    end
  end

  assign accept        = (state_q == IDLE) && win_found;
  assign req.req_ready = (accept && !rst) ? (NUM_REQ'(1) << win_idx) : '0;

  // FSM next state, note capture and end-of-note detection.
  always_comb begin
    state_d    = state_q;
    tone_d     = tone_q;
    dur_d      = dur_q;
    gid_d      = gid_q;
    gap_d      = gap_q;
    restart    = 1'b0;
    note_done  = 1'b0;
    last_cycle = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tone_d  = win_tone;
          dur_d   = win_dur;
          gid_d   = win_idx;
          restart = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (dur_q == '0) begin
          last_cycle = 1'b1;
        end else if (tick) begin
          dur_d = dur_dec(dur_q);
          if (dur_q == DUR_W'(1)) begin
            last_cycle = 1'b1;
          end
        end
        if (last_cycle || abort) begin
          note_done = 1'b1;
          restart   = 1'b1;
          gap_d     = GAP_CNT_W'(GAP_TICKS);
          state_d   = (GAP_TICKS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (tick) begin
          gap_d = gap_q - GAP_CNT_W'(1);
          if (gap_q <= GAP_CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs to the tone generator; silent outside PLAY and for zero-length notes.
  always_comb begin
    tone_switch_period = (state_q == PLAY) ? tone_q : '0;
    output_enable      = (state_q == PLAY) && (tone_q != '0) && (dur_q != '0);
    busy               = (state_q != IDLE);
    grant_id           = gid_q;
  end

  // Control registers, cleared asynchronously so a reset silences at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      gap_q   <= gap_d;
    end
  end

  // Captured note data; only observed while PLAY, so it carries no reset.
  always_ff @(posedge clk) begin
    tone_q <= tone_d;
    dur_q  <= dur_d;
  end

`ifdef TONE_ARB_ROUND_ROBIN_EN
  assign ptr_d = accept ? win_idx : ptr_q;

  // Round-robin pointer, moved only when a note is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares the single piezo `tone_generator` among several note sources (music streamer, keypad, alarm, and so on). Each requester offers a tone period plus a duration in milliseconds. The arbiter grants one requester at a time, drives the tone generator's `tone_switch_period`/`output_enable` for exactly the requested duration, then inserts an articulation gap before the next grant. It sits between the note sources and `tone_generator` in the lab top level.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TICK_CYCLES`, 33000: clk cycles per duration tick (1 ms at ~33 MHz).
- `GAP_TICKS`, 10: silent ticks after every note; 0 means no gap.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has a note pending.
- `req_ready`  out  NUM_REQ  one-hot acceptance; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `req_tone`  in  24*NUM_REQ  tone period; requester i occupies bits `[24*i +: 24]`. 0 means rest.
- `req_duration`  in  16*NUM_REQ  note length in ticks; requester i occupies bits `[16*i +: 16]`.
- `abort`  in  1  cut the current note short.
- `tone_switch_period`  out  24  to `tone_generator`.
- `output_enable`  out  1  to `tone_generator`.
- `grant_id`  out  clog2(NUM_REQ)  owner of the current or last note.
- `busy`  out  1  high in PLAY or GAP.
- `note_done`  out  1  one-cycle pulse at the end of each note.

## Operation
- FSM states: IDLE, PLAY, GAP.
- **IDLE**
  - If any `req_valid` is high, the winner is selected combinationally and its `req_ready` is high in the same cycle.
  - The arbiter captures the winner's tone, duration and id, restarts the tick counter, and goes to PLAY.
  - `req_ready` is only ever high in IDLE, and only for the winner.
- **PLAY**
  - `tone_switch_period` = captured tone.
  - `output_enable` = 1 if the tone is nonzero, else 0 (rest).
  - The duration counter decrements on each tick. When it reaches 0: pulse `note_done` and go to GAP.
  - Duration 0: accept, pass through PLAY for one cycle, pulse `note_done` there, then GAP.
- **GAP**
  - `output_enable` = 0 and `tone_switch_period` = 0.
  - Stay for `GAP_TICKS` ticks, then IDLE.
  - If `GAP_TICKS` = 0, go directly to IDLE.
- **abort**
  - In PLAY: go to GAP on the next edge and pulse `note_done`.
  - If abort coincides with natural expiry, only one `note_done` is produced.
  - Ignored in IDLE and GAP.
- Requests are level-held. A requester that drops valid before being granted is simply skipped. Inputs are sampled only in the acceptance cycle.
- Arbitration policy is set by the macro in Configuration.

## Timing
- Reset values: `tone_switch_period` = 0, `output_enable` = 0, `grant_id` = 0, `busy` = 0, `note_done` = 0, `req_ready` = 0. State = IDLE, tick counter = 0, round-robin pointer = NUM_REQ-1.
- Reset mid-note silences the output immediately (asynchronous). The note is lost and no `note_done` is produced.
- Acceptance cycle A: PLAY outputs are valid from A+1.
- A note occupies PLAY for exactly `duration*TICK_CYCLES` cycles (1 cycle when duration = 0). `note_done` is high in the last PLAY cycle.
- GAP lasts `GAP_TICKS*TICK_CYCLES` cycles. The earliest next acceptance is the first IDLE cycle after GAP.
- Tick counter width is clog2(TICK_CYCLES). It wraps at TICK_CYCLES-1 and the tick pulse is emitted on the wrap.
- The duration counter is 16 bits and never wraps: it stops at 0.

## Configuration
- `TONE_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. The search starts at (last `grant_id` + 1) mod NUM_REQ.
  - The pointer updates only on acceptance.
  - Starvation-free: any continuously valid requester is granted within NUM_REQ notes.
- Undefined: fixed priority, with the lowest index winning. No pointer register is present.

## Structure
- Package `tone_pkg` holds:
  - `TONE_W` = 24 and `DUR_W` = 16.
  - The FSM state typedef (IDLE/PLAY/GAP).
  - The helper function for the index width.
- Sub-module `tick_gen` (params `TICK_CYCLES`; ports `clk`, `rst`, `restart`, `tick`) holds the free-running tick counter with synchronous restart.
- The arbiter core and FSM stay in `tone_arbiter`.

## Test plan
Benches use `TICK_CYCLES` = 4, `GAP_TICKS` = 1, `NUM_REQ` = 4.
- Single request: req 2 with tone 0x00BEEF and duration 3. Expect `req_ready[2]` for 1 cycle, then `output_enable` = 1 and `tone_switch_period` = 0x00BEEF for exactly 12 cycles, `note_done` in the 12th, then 4 silent cycles, then IDLE.
- Contention: reqs 0, 1 and 3 valid continuously, each with duration 1.
  - With the macro: grants are 0, 1, 3, 0.
  - Without the macro: grants are 0, 0, 0.
- Rest note: tone 0 with duration 2 gives `output_enable` = 0 for 8 cycles, `busy` = 1, and one `note_done`.
- Duration 0: `req_ready` and `note_done` occur one cycle apart, the note has no audible cycles, then GAP.
- Abort: duration 100, abort at cycle 5 of PLAY. Expect `output_enable` low on the next edge, a single `note_done`, then GAP. Abort asserted coincident with the last PLAY cycle also gives exactly one `note_done`.
- Reset: assert `rst` mid-PLAY asynchronously. All outputs drop to 0 before the next clock edge. The round-robin pointer is restored, so req 0 wins next.
